tmds_decoder: RTL

Receive-side counterpart of the HDMI TMDS channel encoder. It takes 10-bit parallel words from a per-channel deserializer, runs a word-alignment state machine that requests bit slips until control-period tokens are found, and then reports lock. Once locked, it decodes each word into 8-bit pixel data, a 2-bit control value and a data-enable flag. One instance sits per TMDS channel, between the deserializer and the video timing/capture logic.

---
 rtl/tmds_decoder_pkg.sv | 27 ++
 rtl/tmds_decoder_word_align.sv | 99 +++++++++
 rtl/tmds_decoder.sv | 84 ++++++++
 3 files changed

// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS definitions: control-period tokens, the ctrl-to-token mapping and the
// word-alignment FSM state type.
package tmds_decoder_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'h354;
    localparam logic [9:0] TOKEN_C01 = 10'h0AB;
    localparam logic [9:0] TOKEN_C10 = 10'h154;
    localparam logic [9:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        StSearch   = 2'd0,
        StSlipWait = 2'd1,
        StLocked   = 2'd2
    } align_state_e;

    function automatic logic [9:0] ctrl_to_token(input logic [1:0] c);
        logic [9:0] tok;
        unique case (c)
            2'b00:   tok = TOKEN_C00;
            2'b01:   tok = TOKEN_C01;
            2'b10:   tok = TOKEN_C10;
            default: tok = TOKEN_C11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_decoder_word_align.sv
// Word-alignment FSM: counts consecutive control tokens to declare lock, requests
// bit slips while searching and drops lock when control runs stop arriving.
module tmds_decoder_word_align
    import tmds_decoder_pkg::*;
#(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_SETTLE    = 4,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic is_ctrl_i,
    output logic locked_o,
    output logic locked_d_o,
    output logic bitslip_o
);

    localparam int unsigned TimeoutMax = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT
                                                                         : LOSS_TIMEOUT;
    localparam int unsigned TimerMax   = (TimeoutMax > SLIP_SETTLE) ? TimeoutMax : SLIP_SETTLE;
    localparam int unsigned TimerW     = (TimerMax > 1) ? $clog2(TimerMax) : 1;
    localparam int unsigned RunW       = $clog2(CTRL_RUN + 1);

    align_state_e      state_d, state_q;
    logic [TimerW-1:0] timer_d, timer_q;
    logic [RunW-1:0]   run_d, run_q;
    logic              locked_d, locked_q;
    logic              bitslip_d, bitslip_q;
    logic              run_hit;

    always_comb begin
        run_d = '0;
        if (state_q != StSlipWait && is_ctrl_i) begin
            run_d = (run_q == RunW'(CTRL_RUN)) ? run_q : run_q + 1'b1;
        end
        // A saturated run keeps hitting, so a steady control period keeps lock refreshed.
        run_hit = (run_d == RunW'(CTRL_RUN));

        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        locked_d  = locked_q;
        bitslip_d = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (run_hit) begin
                    state_d  = StLocked;
                    timer_d  = '0;
                    locked_d = 1'b1;
                end else if (timer_q == TimerW'(SEARCH_TIMEOUT - 1)) begin
                    state_d   = StSlipWait;
                    timer_d   = '0;
                    bitslip_d = 1'b1;
                end
            end
            StSlipWait: begin
                if (timer_q == TimerW'(SLIP_SETTLE - 1)) begin
                    state_d = StSearch;
                    timer_d = '0;
                end
            end
            StLocked: begin
                if (run_hit) begin
                    timer_d = '0;
                end else if (timer_q == TimerW'(LOSS_TIMEOUT - 1)) begin
                    state_d  = StSearch;
                    timer_d  = '0;
                    locked_d = 1'b0;
                end
            end
            default: begin
                state_d  = StSearch;
                timer_d  = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StSearch;
            timer_q   <= '0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            bitslip_q <= bitslip_d;
        end
    end

    assign locked_o   = locked_q;
    assign locked_d_o = locked_d;
    assign bitslip_o  = bitslip_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: classifies each 10-bit word, decodes data words and
// registers data/ctrl/de with one cycle of latency behind the alignment FSM.
module tmds_decoder
    import tmds_decoder_pkg::*;
#(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_SETTLE    = 4,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic       bitslip
);

    logic       is_ctrl;
    logic [1:0] tok_ctrl;
    logic [7:0] q;
    logic [7:0] dec;
    logic       lock_next;
    logic [7:0] data_d, data_q;
    logic [1:0] ctrl_d, ctrl_q;
    logic       de_d, de_q;

    always_comb begin
        is_ctrl  = 1'b0;
        tok_ctrl = 2'b00;
        for (int c = 0; c < 4; c++) begin
            if (tmds_in == ctrl_to_token(2'(c))) begin
                is_ctrl  = 1'b1;
                tok_ctrl = 2'(c);
            end
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q   = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        dec = {q[7:1] ^ q[6:0] ^ {7{~tmds_in[8]}}, q[0]};
    end

    tmds_decoder_word_align #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_SETTLE    (SLIP_SETTLE),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) u_align (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .is_ctrl_i  (is_ctrl),
        .locked_o   (locked),
        .locked_d_o (lock_next),
        .bitslip_o  (bitslip)
    );

    // de follows the next lock state so it drops on the same edge as locked.
    always_comb begin
        data_d = is_ctrl ? data_q : dec;
        ctrl_d = is_ctrl ? tok_ctrl : ctrl_q;
        de_d   = ~is_ctrl & lock_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
        end
    end

    assign data = data_q;
    assign ctrl = ctrl_q;
    assign de   = de_q;

endmodule
